serializer_scheduler: RTL
=========================

// Module: serializer_scheduler
// PURPOSE
//  Round-robin scheduler sharing one 8-bit serializer (base_serializer-style: par_data/divider/store/empty)
//  between NUM_REQ requesters. Holds a per-requester bit-clock divider, issues one store per granted byte,
//  tracks the serializer's empty handshake and pulses ack to the owner when its byte has fully shifted out.
// PARAMETERS
//  NUM_REQ        4      number of requesters (2..8)
//  DIV_RESET      32'd7  reset value of every per-requester divider register
//  BUSY_WAIT      4      max cycles after store for ser_empty to fall before the store is reissued
//  TIMEOUT_CYCLES 4096   max cycles in WAIT_EMPTY (used only with SER_SCHED_TIMEOUT_EN)
// PORTS
//  clock         in   1          single clock, all logic on posedge
//  reset_n       in   1          synchronous, active-low reset
//  req           in   NUM_REQ    level request; held until matching ack
//  req_data      in   NUM_REQ*8  byte of requester i at [8i+7:8i]; sampled at grant
//  ack           out  NUM_REQ    one-cycle completion pulse, one-hot
//  err           out  1          one-cycle pulse with ack when transfer aborted (timeout)
//  cfg_we        in   1          write divider register cfg_sel with cfg_divider
//  cfg_sel       in   IDX_W      requester index, IDX_W = clog2(NUM_REQ)
//  cfg_divider   in   32         divider value
//  busy          out  1          high from grant through ack cycle
//  grant_id      out  IDX_W      current owner; valid while busy
//  ser_par_data  out  8          byte to serializer, stable from STORE through DONE
//  ser_divider   out  32         owner's divider, stable from STORE through DONE
//  ser_store     out  1          one-cycle store pulse
//  ser_empty     in   1          serializer idle flag (1 = empty)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state IDLE; ack, err, busy, ser_store=0; ser_par_data=0; ser_divider=0;
//   grant_id=0; rr pointer=0 (requester 0 has highest priority first); all dividers=DIV_RESET.
//   Reset mid-transfer abandons the owner without ack; requester must keep req and be rescheduled.
//  FSM: IDLE -> STORE -> WAIT_BUSY -> WAIT_EMPTY -> DONE -> IDLE.
//   IDLE: if |req and ser_empty=1, grant first set req at or after pointer (wrap); latch byte+divider; busy=1.
//         If ser_empty=0 in IDLE, no grant (serializer owned elsewhere/finishing).
//   STORE: ser_store=1 for exactly one cycle.
//   WAIT_BUSY: wait ser_empty=0 -> WAIT_EMPTY; after BUSY_WAIT cycles without it, back to STORE (reissue).
//   WAIT_EMPTY: wait ser_empty=1 -> DONE.
//   DONE: ack[grant_id]=1 one cycle; pointer = grant_id+1 mod NUM_REQ; busy drops next cycle.
//  Latency: req seen in IDLE -> ser_store 1 cycle later; ser_empty rise -> ack 1 cycle later.
//  Min gap between consecutive stores: 2 cycles idle (DONE, IDLE).
//  req dropped while owned: transfer completes, ack still pulses. New req during busy: queued by level.
//  cfg_we to owner's register mid-transfer: takes effect next grant; ser_divider unchanged.
//  cfg_sel >= NUM_REQ: write ignored. Simultaneous cfg_we and grant of same index: grant uses old value.
// CONFIGURATION
//  SER_SCHED_TIMEOUT_EN defined: 32-bit counter in WAIT_EMPTY; at TIMEOUT_CYCLES without ser_empty=1,
//   go to DONE with ack and err pulsed together; pointer advances normally.
//  Not defined: WAIT_EMPTY waits indefinitely; err tied 0; no counter logic.
// STRUCTURE
//  ser_sched_pkg: state encoding (IDLE, STORE, WAIT_BUSY, WAIT_EMPTY, DONE), DIV_W=32, DATA_W=8.
//  Sub-module rr_arbiter: req vector + pointer -> one-hot grant and index, purely combinational.
// TESTING
//  1 Reset: hold reset_n=0 two cycles with req=4'b1111 -> no store, ack=0, busy=0, ser_divider=0.
//  2 Single: req[2]=1, data 8'hA5, cfg div 2=32'd3 -> ser_store next cycle, ser_par_data=A5,
//    ser_divider=3; model empty low 10 cycles -> ack=4'b0100 one cycle after empty rises.
//  3 Round-robin: req=4'b1011 held -> grant order 0,1,3,0 with one store each.
//  4 Lost store: ser_empty never falls -> store reissued every BUSY_WAIT+1 cycles; fall -> normal ack.
//  5 Timeout (EN, TIMEOUT_CYCLES=16): empty stuck low -> ack+err on cycle 17 of WAIT_EMPTY;
//    without macro -> no ack after 100 cycles, err=0.
//  6 Reset mid-transfer in WAIT_EMPTY -> IDLE, no ack, divider regs back to 7, pointer 0.

Source files
------------

// File: rtl/ser_sched_pkg.sv
// Shared types and widths for the serializer scheduler.
// State encoding for the transfer FSM plus data/divider widths.
package ser_sched_pkg;

    localparam int DIV_W  = 32;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_WAIT_BUSY,
        S_WAIT_EMPTY,
        S_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set request at or after the pointer, wrapping.
module rr_arbiter
    import ser_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    logic [IDX_W-1:0] w_pos;
    logic             w_found;

    // scan from the pointer and take the first pending request
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/serializer_scheduler.sv
// Round-robin scheduler sharing one byte serializer among requesters.
// Optional WAIT_EMPTY timeout (ack+err) enabled by SER_SCHED_TIMEOUT_EN.
module serializer_scheduler
    import ser_sched_pkg::*;
#(
    parameter  int               NUM_REQ        = 4,
    parameter  logic [DIV_W-1:0] DIV_RESET      = 32'd7,
    parameter  int               BUSY_WAIT      = 4,
    parameter  int               TIMEOUT_CYCLES = 4096,
    localparam int               IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err,
    input  logic                      cfg_we,
    input  logic [IDX_W-1:0]          cfg_sel,
    input  logic [DIV_W-1:0]          cfg_divider,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic [DATA_W-1:0]         ser_par_data,
    output logic [DIV_W-1:0]          ser_divider,
    output logic                      ser_store,
    input  logic                      ser_empty
);

    localparam int BW_W = $clog2(BUSY_WAIT + 1);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant_id;
    logic [DATA_W-1:0]  r_data;
    logic [DIV_W-1:0]   r_ser_div;
    logic [DIV_W-1:0]   r_div [NUM_REQ];
    logic [BW_W-1:0]    r_bw_cnt;
    logic               w_bw_expired;
    logic               w_timeout;
    logic [NUM_REQ-1:0] w_arb_grant;
    logic [IDX_W-1:0]   w_arb_idx;
    logic [DATA_W-1:0]  w_sel_data;
    logic [DIV_W-1:0]   w_sel_div;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx)
    );

    assign w_bw_expired = (r_bw_cnt == BW_W'(BUSY_WAIT - 1));
    assign grant_id     = r_grant_id;
    assign ser_par_data = r_data;
    assign ser_divider  = r_ser_div;

`ifdef SER_SCHED_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_to_flag;

    assign w_timeout = (r_state == S_WAIT_EMPTY) && !ser_empty &&
                       (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign err = (r_state == S_DONE) && r_to_flag;

    // count cycles spent draining; remember an abort until the ack
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == S_WAIT_EMPTY) ? r_to_cnt + 32'd1 : '0;
            if (r_state == S_IDLE)
                r_to_flag <= 1'b0;
            else if (w_timeout)
                r_to_flag <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // mux the granted requester's byte and divider
    always_comb begin
        w_sel_data = '0;
        w_sel_div  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_grant[i]) begin
                w_sel_data = w_sel_data | req_data[i*DATA_W +: DATA_W];
                w_sel_div  = w_sel_div | r_div[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_next    = r_state;
        ser_store = 1'b0;
        ack       = '0;
        busy      = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (ser_empty && (|w_arb_grant))
                    w_next = S_STORE;
            end
            S_STORE: begin
                ser_store = 1'b1;
                w_next    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!ser_empty)
                    w_next = S_WAIT_EMPTY;
                else if (w_bw_expired)
                    w_next = S_STORE;
            end
            S_WAIT_EMPTY: begin
                if (ser_empty || w_timeout)
                    w_next = S_DONE;
            end
            S_DONE: begin
                ack[r_grant_id] = 1'b1;
                w_next          = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // per-requester divider registers; out-of-range selects are dropped
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++)
                r_div[i] <= DIV_RESET;
        end else if (cfg_we && (int'(cfg_sel) < NUM_REQ)) begin
            r_div[cfg_sel] <= cfg_divider;
        end
    end

    // grant latching, rr pointer and store-reissue counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_data     <= '0;
            r_ser_div  <= '0;
            r_bw_cnt   <= '0;
        end else begin
            if ((r_state == S_IDLE) && (w_next == S_STORE)) begin
                r_grant_id <= w_arb_idx;
                r_data     <= w_sel_data;
                r_ser_div  <= w_sel_div;
            end
            if (r_state == S_DONE)
                r_ptr <= (int'(r_grant_id) == NUM_REQ - 1) ?
                         '0 : r_grant_id + 1'b1;
            r_bw_cnt <= (r_state == S_WAIT_BUSY) ? r_bw_cnt + 1'b1 : '0;
        end
    end

endmodule
